// File: rtl/sbus_mem_arbiter.sv
// SimpleBus memory front-end: round-robin arbitration of NUM_M masters onto one memory port,
// one transaction outstanding. Optional random extra latency via SBUS_RAND_DELAY_EN.
module sbus_mem_arbiter #(
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          req_valid,
  output logic [NUM_M-1:0]          req_ready,
  input  logic [NUM_M*ADDR_W-1:0]   req_addr,
  input  logic [NUM_M-1:0]          req_wen,
  input  logic [NUM_M*DATA_W-1:0]   req_wdata,
  input  logic [NUM_M*DATA_W/8-1:0] req_wmask,
  output logic [NUM_M-1:0]          rsp_valid,
  input  logic [NUM_M-1:0]          rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_wmask,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned OwnW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  // Wide enough for LATENCY-1 plus up to 7 random extra cycles.
  localparam int unsigned CntW  = 9;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [OwnW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OwnW-1:0]   owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]  wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_found;
  logic [OwnW-1:0]   gnt_idx;
  logic [NUM_M-1:0]  gnt_oh;
  logic [NUM_M-1:0]  own_oh;
  logic [ADDR_W-1:0] addr_sel;
  logic              wen_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [MaskW-1:0]  wmask_sel;
  logic              accept;
  logic              own_rdy;
  logic              mem_fire;
  logic [CntW-1:0]   lat_init;

`ifdef SBUS_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lat_init = CntW'(LATENCY - 1) + CntW'(lfsr_q[2:0]);
`else
  assign lat_init = CntW'(LATENCY - 1);
`endif

  // Round-robin search: first requester at or above rr_ptr, else wrap to the lowest.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (!gnt_found && req_valid[i] && (i >= 32'(rr_ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = OwnW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = OwnW'(i);
      end
    end
  end

  always_comb begin
    gnt_oh    = '0;
    own_oh    = '0;
    addr_sel  = '0;
    wen_sel   = 1'b0;
    wdata_sel = '0;
    wmask_sel = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      gnt_oh[i] = gnt_found && (gnt_idx == OwnW'(i));
      own_oh[i] = (owner_q == OwnW'(i));
      if (gnt_oh[i]) begin
        addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
        wen_sel   = req_wen[i];
        wdata_sel = req_wdata[i*DATA_W +: DATA_W];
        wmask_sel = req_wmask[i*MaskW +: MaskW];
      end
    end
  end

  assign accept   = rst && (state_q == StIdle) && gnt_found;
  assign own_rdy  = |(rsp_ready & own_oh);
  assign mem_fire = rst && (state_q == StWait) && (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = addr_sel;
          wen_d    = wen_sel;
          wdata_d  = wdata_sel;
          wmask_d  = wmask_sel;
          owner_d  = gnt_idx;
          cnt_d    = lat_init;
          rr_ptr_d = (gnt_idx == OwnW'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdata_d = wen_q ? '0 : mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        if (own_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs are gated by rst so an in-flight transaction vanishes as soon as reset asserts.
  always_comb begin
    req_ready = accept ? gnt_oh : '0;
    rsp_valid = (rst && (state_q == StResp)) ? own_oh : '0;
    rsp_rdata = rdata_q;
    mem_en    = mem_fire;
    mem_we    = mem_fire && wen_q;
    mem_addr  = mem_fire ? addr_q : '0;
    mem_wdata = mem_fire ? wdata_q : '0;
    mem_wmask = mem_fire ? wmask_q : '0;
  end

endmodule

// File: tb/tb_sbus_mem_arbiter.sv
// Directed bench for sbus_mem_arbiter: a LATENCY=1 instance for reset, read, write,
// backpressure and round-robin, and a LATENCY=4 instance for mid-transaction reset.
module tb_sbus_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst4 = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, req_wen, rsp_valid, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wmask;

  logic [1:0]  req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [31:0] rsp_rdata4, mem_addr4, mem_wdata4;
  logic        mem_en4, mem_we4;
  logic [3:0]  mem_wmask4;

  int n_checks = 0;
  int n_fail = 0;

  sbus_mem_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  sbus_mem_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst4),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_rdata(rsp_rdata4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_wmask(mem_wmask4), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_oh;
    req_valid  = 2'b11;
    req_addr   = '0;
    req_wen    = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    rsp_ready  = '0;
    mem_rdata  = '0;
    req_valid4 = '0;
    rsp_ready4 = '0;

    // Reset held with everyone requesting
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
    end
    req_valid = '0;
    rst = 1'b1;
    tick;
    chk("idle_rsp_rdata", 64'(rsp_rdata), 64'd0);

    // Single read from master 0
    req_valid = 2'b01;
    req_addr[31:0] = 32'h8000_0000;
    mem_rdata = 32'h0010_0073;
    #1;
    chk("rd_grant", 64'(req_ready), 64'h1);
    tick;
    req_valid = '0;
    #1;
    chk("rd_mem_en", 64'(mem_en), 64'h1);
    chk("rd_mem_we", 64'(mem_we), 64'h0);
    chk("rd_mem_addr", 64'(mem_addr), 64'h8000_0000);
    chk("rd_rsp_early", 64'(rsp_valid), 64'h0);
    tick;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h0010_0073);
    chk("rd_mem_en_off", 64'(mem_en), 64'h0);
    chk("rd_mem_addr_off", 64'(mem_addr), 64'h0);

    // Backpressure: owner not ready, non-owner's rsp_ready must be ignored
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'h0010_0073);
      chk("bp_req_ready", 64'(req_ready), 64'h0);
      chk("bp_mem_en", 64'(mem_en), 64'h0);
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = '0;
    #1;
    chk("bp_released", 64'(rsp_valid), 64'h0);
    chk("rr_after_m0", 64'(req_ready), 64'h2);

    // Write from master 1
    req_valid = 2'b10;
    req_addr[63:32] = 32'h8000_0004;
    req_wen = 2'b10;
    req_wdata[63:32] = 32'hDEAD_BEEF;
    req_wmask[7:4] = 4'b0011;
    #1;
    chk("wr_grant", 64'(req_ready), 64'h2);
    tick;
    req_valid = '0;
    req_wen = '0;
    #1;
    chk("wr_mem_en", 64'(mem_en), 64'h1);
    chk("wr_mem_we", 64'(mem_we), 64'h1);
    chk("wr_mem_addr", 64'(mem_addr), 64'h8000_0004);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("wr_mem_wmask", 64'(mem_wmask), 64'h3);
    tick;
    chk("wr_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("wr_mem_we_off", 64'(mem_we), 64'h0);
    rsp_ready = 2'b10;
    tick;
    rsp_ready = '0;

    // Round-robin with both masters requesting continuously
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      mem_rdata = 32'hA000_0000 + 32'(k);
      #1;
      chk("rr_grant", 64'(req_ready), 64'(exp_oh));
      tick;
      tick;
      chk("rr_rsp_valid", 64'(rsp_valid), 64'(exp_oh));
      chk("rr_rsp_rdata", 64'(rsp_rdata), 64'hA000_0000 + 64'(k));
      tick;
    end
    req_valid = '0;
    rsp_ready = '0;

    // LATENCY=4: accept from m0, then reset two cycles into WAIT
    rst4 = 1'b1;
    tick;
    chk("l4_idle_ready", 64'(req_ready4), 64'h0);
    req_valid4 = 2'b01;
    #1;
    chk("l4_grant_m0", 64'(req_ready4), 64'h1);
    tick;
    req_valid4 = '0;
    #1;
    chk("l4_wait1_mem_en", 64'(mem_en4), 64'h0);
    tick;
    chk("l4_wait2_mem_en", 64'(mem_en4), 64'h0);
    rst4 = 1'b0;
    tick;
    chk("l4_rst_mem_en", 64'(mem_en4), 64'h0);
    chk("l4_rst_rsp_valid", 64'(rsp_valid4), 64'h0);
    rst4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("l4_post_rst_mem_en", 64'(mem_en4), 64'h0);
      chk("l4_post_rst_rsp", 64'(rsp_valid4), 64'h0);
    end
    req_valid4 = 2'b11;
    #1;
    chk("l4_post_rst_grant", 64'(req_ready4), 64'h1);

    // Full LATENCY=4 transaction timing
    tick;
    req_valid4 = '0;
    #1;
    for (int j = 0; j < 4; j++) begin
      chk("l4_mem_en_timing", 64'(mem_en4), (j == 3) ? 64'h1 : 64'h0);
      chk("l4_rsp_early", 64'(rsp_valid4), 64'h0);
      tick;
    end
    chk("l4_rsp_valid", 64'(rsp_valid4), 64'h1);
    rsp_ready4 = 2'b01;
    tick;
    chk("l4_rsp_done", 64'(rsp_valid4), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
